// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter
//   Round-robin arbiter that lets NUM_REQ requesters push into one downstream
//   FIFO. A requester that wins keeps ownership for up to the burst limit of
//   consecutive accepts, stalls (without losing ownership) while the FIFO is
//   full, and hands over through one idle bubble cycle.
//
//   Build option: define FIFO_ARB_BURST_EN to allow bursts of up to BURST_LEN
//   accepts per ownership. Without it every ownership is a single accept
//   (pure per-entry round-robin) and BURST_LEN has no effect.
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   req         per-requester level push request
//   data_i      requester k data at [k*DATA_WIDTH +: DATA_WIDTH]
//   grant       one-hot, requester whose data is sampled this cycle
//   owner       current or last granted requester
//   fifo_count  downstream FIFO occupancy
//   fifo_push   registered push to the downstream FIFO
//   fifo_data   registered data to the downstream FIFO
module fifo_push_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 64,
  parameter int BURST_LEN  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   data_i,
  output logic [NUM_REQ-1:0]              grant,
  output logic [$clog2(NUM_REQ)-1:0]      owner,
  input  logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            fifo_push,
  output logic [DATA_WIDTH-1:0]           fifo_data
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

`ifdef FIFO_ARB_BURST_EN
  localparam logic [7:0] LIMIT = 8'(BURST_LEN);
`else
  // Single accept per ownership; BURST_LEN is deliberately ignored.
  localparam logic [7:0] LIMIT = (BURST_LEN > 0) ? 8'd1 : 8'd1;
`endif

  typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr;
  logic [7:0]      bcnt;
  logic            space;
  logic            sel_vld;
  logic [IW-1:0]   sel_idx;
  logic            gnt_vld;
  logic [IW-1:0]   gnt_idx;
  logic            serve_exit;
  logic [CW:0]     occupancy;

  // The push registered last cycle is not yet visible in fifo_count.
  assign occupancy = {1'b0, fifo_count} + (CW+1)'(fifo_push);
  assign space     = occupancy < (CW+1)'(FIFO_DEPTH);

  // First requesting index searching ptr, ptr+1, ... modulo NUM_REQ.
  always_comb begin
    logic [IW:0] cand;
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + (IW+1)'(i);
      if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
      if (!sel_vld && req[cand[IW-1:0]]) begin
        sel_vld = 1'b1;
        sel_idx = cand[IW-1:0];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state and accept decision
  always_comb begin
    state_nxt  = state;
    gnt_vld    = 1'b0;
    gnt_idx    = owner;
    serve_exit = 1'b0;
    case (state)
      IDLE: begin
        if (sel_vld && space) begin
          gnt_vld   = 1'b1;
          gnt_idx   = sel_idx;
          state_nxt = SERVE;
        end
      end
      SERVE: begin
        // Exit cycle never grants: it is the bubble between owners.
        if (!req[owner] || bcnt >= LIMIT) begin
          state_nxt  = IDLE;
          serve_exit = 1'b1;
        end else if (space) begin
          gnt_vld = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs; reset masks grant immediately, not only at the next edge.
  always_comb begin
    grant = '0;
    if (gnt_vld && !rst) grant[gnt_idx] = 1'b1;
  end

  // Ownership, burst count, pointer and FIFO push register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      owner     <= '0;
      bcnt      <= '0;
      fifo_push <= 1'b0;
      fifo_data <= '0;
    end else begin
      fifo_push <= gnt_vld;
      if (gnt_vld) fifo_data <= data_i[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
      if (state == IDLE && gnt_vld) begin
        owner <= gnt_idx;
        bcnt  <= 8'd1;
      end else if (state == SERVE && gnt_vld) begin
        bcnt <= bcnt + 8'd1;
      end
      if (serve_exit) begin
        bcnt <= '0;
        if (owner == IW'(NUM_REQ - 1)) ptr <= '0;
        else                           ptr <= owner + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
module tb_fifo_push_arbiter;

  localparam int DW = 32;
  localparam int NR = 4;
  localparam int FD = 8;
  localparam int BL = 4;
`ifdef FIFO_ARB_BURST_EN
  localparam int LIMIT = BL;
`else
  localparam int LIMIT = 1;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  data_i;
  logic [NR-1:0]     grant;
  logic [1:0]        owner;
  logic [3:0]        fifo_count;
  logic              fifo_push;
  logic [DW-1:0]     fifo_data;

  fifo_push_arbiter #(
    .DATA_WIDTH(DW), .NUM_REQ(NR), .FIFO_DEPTH(FD), .BURST_LEN(BL)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .data_i(data_i), .grant(grant),
    .owner(owner), .fifo_count(fifo_count), .fifo_push(fifo_push),
    .fifo_data(fifo_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int gidx(input logic [NR-1:0] g);
    int r;
    r = -1;
    for (int i = 0; i < NR; i++)
      if (g[i]) r = (r == -1) ? i : -2;
    return r;
  endfunction

  // Reference model: a "session" is one requester's ownership with a number
  // of accepts still allowed; the FIFO side is one pending push plus data.
  bit            m_in_session;
  int            m_owner;
  int            m_left;
  int            m_next;
  bit            m_push;
  logic [DW-1:0] m_data;
  int            exp_g;
  logic [NR-1:0] exp_vec;

  always @(negedge clk) begin
    if (rst) begin
      m_in_session = 0; m_owner = 0; m_left = 0; m_next = 0;
      m_push = 0; m_data = '0;
      check("rst_grant", grant, 0);
      check("rst_push", fifo_push, 0);
      check("rst_owner", owner, 0);
    end else begin
      check("push", fifo_push, m_push);
      check("data", fifo_data, m_data);
      check("owner", owner, m_owner);
      exp_g = -1;
      if (!m_in_session) begin
        for (int i = 0; i < NR; i++)
          if (exp_g < 0 && req[(m_next + i) % NR]) exp_g = (m_next + i) % NR;
        if (int'(fifo_count) + int'(m_push) >= FD) exp_g = -1;
        if (exp_g >= 0) begin
          m_in_session = 1;
          m_owner      = exp_g;
          m_left       = LIMIT - 1;
        end
      end else if (!req[m_owner] || m_left == 0) begin
        m_in_session = 0;
        m_next       = (m_owner + 1) % NR;
      end else if (int'(fifo_count) + int'(m_push) < FD) begin
        exp_g = m_owner;
        m_left--;
      end
      exp_vec = '0;
      if (exp_g >= 0) exp_vec[exp_g] = 1'b1;
      check("grant", grant, exp_vec);
      m_push = (exp_g >= 0);
      if (exp_g >= 0) m_data = data_i[exp_g*DW +: DW];
    end
  end

  task automatic pattern_data();
    for (int k = 0; k < NR; k++) data_i[k*DW +: DW] = 32'hA000_0000 + k;
  endtask

  task automatic reset_release();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  int            trace[10];
  logic [DW-1:0] dtrace[10];
  int            exp_rr[10];
  int            exp_bp[8];
  int            ngr;

  initial begin
    rst = 1'b1; req = '0; data_i = '0; fifo_count = '0;
    pattern_data();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Quiet requesters after reset
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("quiet_grant", grant, 0);
      check("quiet_push", fifo_push, 0);
      check("quiet_owner", owner, 0);
    end

    // All requesting, empty FIFO: grant order and data one cycle later
`ifdef FIFO_ARB_BURST_EN
    exp_rr = '{0, 0, 0, 0, -1, 1, 1, 1, 1, -1};
`else
    exp_rr = '{0, -1, 1, -1, 2, -1, 3, -1, 0, -1};
`endif
    req = 4'b1111; fifo_count = 0;
    reset_release();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      trace[c]  = gidx(grant);
      dtrace[c] = fifo_data;
    end
    for (int c = 0; c < 10; c++) begin
      check($sformatf("rr_order[%0d]", c), trace[c], exp_rr[c]);
      if (c < 9 && exp_rr[c] >= 0)
        check($sformatf("rr_data[%0d]", c), dtrace[c+1], 32'hA000_0000 + exp_rr[c]);
    end

    // Space accounting with an in-flight push
    req = 4'b0001; fifo_count = 7;
    reset_release();
    @(negedge clk);
    check("space_c0_grant", grant, 4'b0001);
    @(posedge clk); #1;
    @(negedge clk);
    check("space_inflight_push", fifo_push, 1);
    check("space_inflight_grant", grant, 0);
    @(posedge clk); #1 fifo_count = 6;
    @(negedge clk);
    check("space_6_push", fifo_push, 0);
    check("space_6_grant", grant, 4'b0001);

    // Backpressure on owner 2
`ifdef FIFO_ARB_BURST_EN
    exp_bp = '{2, 2, -1, -1, -1, 2, 2, -1};
`else
    exp_bp = '{2, -1, -1, -1, -1, 2, -1, 2};
`endif
    req = 4'b0100; fifo_count = 0;
    reset_release();
    ngr = 0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) begin
        @(posedge clk); #1 fifo_count = (c >= 2 && c <= 4) ? 4'd8 : 4'd0;
      end
      @(negedge clk);
      check($sformatf("bp_order[%0d]", c), gidx(grant), exp_bp[c]);
      if (c == 3) check("bp_owner", owner, 2);
    end

    // Reset mid-burst while a push is registered
    req = 4'b1111; fifo_count = 0;
    reset_release();
    @(negedge clk);
    check("mid_c0_grant", grant, 4'b0001);
    @(posedge clk); #2;
    check("mid_push_before", fifo_push, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_push", fifo_push, 0);
    check("mid_rst_grant", grant, 0);
    check("mid_rst_owner", owner, 0);
    req = 4'b0110;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_after_grant", grant, 4'b0010);

    // Randomized traffic with sticky requests and occasional resets
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      req = req ^ NR'($urandom & $urandom);
      for (int k = 0; k < NR; k++)
        if ($urandom_range(0, 3) == 0) data_i[k*DW +: DW] = $urandom;
      if ($urandom_range(0, 9) < 6) fifo_count = 4'($urandom_range(0, 5));
      else                          fifo_count = 4'($urandom_range(6, 8));
      rst = ($urandom_range(0, 299) == 0);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_push_arbiter.md
FIFO_PUSH_ARBITER -- requirements
Module: fifo_push_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of each data entry.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters (2..16).
REQ-003 SHALL have parameter FIFO_DEPTH, default 64, capacity of the downstream FIFO.
REQ-004 SHALL have parameter BURST_LEN, default 4, maximum consecutive accepts per grant (1..255).
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port req  input  NUM_REQ  per-requester level-sensitive push request.
REQ-008 SHALL have port data_i  input  NUM_REQ*DATA_WIDTH  requester k data at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port grant  output  NUM_REQ  one-hot pulse; grant[k]=1 means data of requester k is sampled this cycle.
REQ-010 SHALL have port owner  output  $clog2(NUM_REQ)  index of the current or last granted requester.
REQ-011 SHALL have port fifo_count  input  $clog2(FIFO_DEPTH)+1  downstream awaiting_count.
REQ-012 SHALL have port fifo_push  output  1  registered push to the downstream FIFO.
REQ-013 SHALL have port fifo_data  output  DATA_WIDTH  registered data to the downstream FIFO.

Function
REQ-014 SHALL accept in a cycle only if space holds: fifo_count + fifo_push < FIFO_DEPTH (accounts for the in-flight push).
REQ-015 SHALL assert at most one grant bit per cycle, never for a requester with req low, never when space is false.
REQ-016 SHALL, on grant[k], register fifo_push=1 and fifo_data=data_i[k] on the same edge (latency 1 cycle); otherwise fifo_push=0 and fifo_data holds.
REQ-017 SHALL keep a round-robin pointer ptr; selection = first requester with req high searching ptr, ptr+1, ... wrapping modulo NUM_REQ.
REQ-018 SHALL implement FSM states IDLE (no owner) and SERVE (owner locked).
REQ-019 SHALL transition IDLE->SERVE when a selection exists and space is true, granting the selected requester in that cycle and setting owner.
REQ-020 SHALL in SERVE grant owner each cycle req[owner]=1 and space is true; burst counter increments per grant.
REQ-021 SHALL leave SERVE->IDLE when req[owner] drops or burst counter reaches the burst limit, setting ptr=(owner+1) mod NUM_REQ.
REQ-022 SHALL, when space is false in SERVE, stall without grant, keeping owner and burst counter (no loss of ownership due to backpressure).
REQ-023 SHALL, on the cycle SERVE exits, allow no grant to a different requester (one IDLE bubble cycle between owners).
REQ-024 SHALL treat req changes of non-owners during SERVE as ignored until IDLE.

Reset
REQ-025 SHALL on rst=1 immediately set state=IDLE, ptr=0, owner=0, burst counter=0, grant=0, fifo_push=0, fifo_data=0.
REQ-026 SHALL on reset mid-burst drop ownership; a push already registered is cleared (fifo_push=0) without completing.
REQ-027 SHALL resume arbitration on the first rising edge after rst deasserts, starting search at requester 0.

Configuration
REQ-028 SHALL support macro FIFO_ARB_BURST_EN: defined -> burst limit = BURST_LEN; undefined -> burst limit = 1 (pure per-entry round-robin) and BURST_LEN unused.

Verification (NUM_REQ=4, FIFO_DEPTH=8, BURST_LEN=4)
REQ-029 SHALL cover: reset, req=4'b0000 -> grant=0, fifo_push=0, owner=0 for 10 cycles.
REQ-030 SHALL cover: req=4'b1111 held, fifo_count=0, macro undefined -> grant order 0,1,2,3,0 with one bubble between each; fifo_data matches each requester one cycle later.
REQ-031 SHALL cover: same with FIFO_ARB_BURST_EN -> 4 consecutive grants to 0, bubble, 4 to 1, etc.
REQ-032 SHALL cover: fifo_count=7, fifo_push=1 (in-flight) -> no grant; fifo_count=6 with no in-flight push -> exactly one grant.
REQ-033 SHALL cover: owner=2 in burst, fifo_count forced 8 for 3 cycles -> no grant, owner stays 2, burst resumes and completes remaining beats.
REQ-034 SHALL cover: rst pulsed while fifo_push=1 mid-burst -> fifo_push=0 and grant=0 asynchronously; next grant goes to lowest-index requesting port.
